rv32i_stage_sequencer: RTL and testbench

Multi-cycle controller for the non-pipelined RV32I datapath. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and skips stages the opcode class does not need. It drives the pipeline-register load enables, the register-file and data-memory strobes, and the PC/writeback selects. It sits beside the IF/ID/EX/MEM stage modules in the top level and replaces free-running, always-active stage wiring.

---
 rtl/rv32i_ctrl_pkg.sv | 61 ++++++
 rtl/rv32i_op_class.sv | 40 ++++
 rtl/rv32i_stage_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32i_stage_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : rv32i_ctrl_pkg
// Description : Shared types for the RV32I multi-cycle stage sequencer.
//               Defines the sequencer state encoding, the RV32I base opcode
//               values, the fault codes and the instruction-class encoding
//               that the opcode classifier produces.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rv32i_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  // RV32I base opcodes (instruction bits [6:0]).
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  // Fault codes reported on o_fault.
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_IMEM_TO = 2'd2,
    FAULT_DMEM_TO = 2'd3
  } fault_e;

  // Instruction classes; each class selects one stage path after DECODE.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ALU     = 3'd5,
    CLS_FENCE   = 3'd6,
    CLS_SYSTEM  = 3'd7
  } op_class_e;

endpackage

`default_nettype wire

// File: rtl/rv32i_op_class.sv
//------------------------------------------------------------------------------
// Module      : rv32i_op_class
// Description : Combinational RV32I opcode classifier. Maps the 7-bit major
//               opcode onto the instruction-class encoding used by the
//               sequencer to choose a stage path.
// Ports       : i_opcode [6:0] - major opcode (instruction bits [6:0])
//               o_class  [2:0] - op_class_e encoding of the opcode
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rv32i_op_class
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      c_OPC_LOAD:   o_class = CLS_LOAD;
      c_OPC_STORE:  o_class = CLS_STORE;
      c_OPC_BRANCH: o_class = CLS_BRANCH;
      c_OPC_JAL,
      c_OPC_JALR:   o_class = CLS_JUMP;
      c_OPC_OP,
      c_OPC_OP_IMM,
      c_OPC_LUI,
      c_OPC_AUIPC:  o_class = CLS_ALU;
      c_OPC_FENCE:  o_class = CLS_FENCE;
      c_OPC_SYSTEM: o_class = CLS_SYSTEM;
      default:      o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_stage_sequencer.sv
//------------------------------------------------------------------------------
// Module      : rv32i_stage_sequencer
// Description : Multi-cycle controller for the non-pipelined RV32I datapath.
//               Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY
//               and WRITEBACK, skipping the stages its class does not use, and
//               drives stage-register enables, regfile/dmem strobes and the
//               PC / writeback selects. Memory waits are bounded by a timeout
//               that parks the block in HALT with a fault code.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_start             - leave IDLE (ignored elsewhere)
//               i_imem_ready        - instruction read data valid
//               i_imem_op [6:0]     - opcode field of instruction read data
//               i_dmem_ready        - data memory access complete
//               i_br_taken          - branch compare result (EXECUTE)
//               o_pc_we, o_pc_sel   - PC load / 0:NPC 1:ALU target
//               o_if_id_we .. o_mem_wb_we - stage register load enables
//               o_reg_we, o_reg_re  - regfile write / store-data read
//               o_dmem_re, o_dmem_we- data memory read / write request
//               o_wb_sel            - 0:memory data 1:ALU result
//               o_busy, o_halted    - activity / HALT state
//               o_fault [1:0]       - 0 none 1 illegal 2 imem TO 3 dmem TO
//               o_retire_pulse      - one cycle per retired instruction
//               o_retire_cnt        - retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rv32i_stage_sequencer
  import rv32i_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_imem_ready,
  input  logic [6:0]          i_imem_op,
  input  logic                i_dmem_ready,
  input  logic                i_br_taken,
  output logic                o_pc_we,
  output logic                o_pc_sel,
  output logic                o_if_id_we,
  output logic                o_id_ex_we,
  output logic                o_ex_mem_we,
  output logic                o_mem_wb_we,
  output logic                o_reg_we,
  output logic                o_reg_re,
  output logic                o_dmem_re,
  output logic                o_dmem_we,
  output logic                o_wb_sel,
  output logic                o_busy,
  output logic                o_halted,
  output logic [1:0]          o_fault,
  output logic                o_retire_pulse,
  output logic [RETIRE_W-1:0] o_retire_cnt
);

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

  state_e                r_state;
  logic [6:0]            r_opcode;
  logic [c_WAIT_W-1:0]   r_wait;
  fault_e                r_fault;
  logic [RETIRE_W-1:0]   r_retire_cnt;

  logic [2:0]            w_class_bits;
  op_class_e             w_class;
  logic                  w_wait_done;
  logic                  w_retire;

  // Classification always works on the latched opcode, never on live imem data.
  rv32i_op_class u_op_class (
    .i_opcode (r_opcode),
    .o_class  (w_class_bits)
  );

  assign w_class     = op_class_e'(w_class_bits);
  assign w_wait_done = (r_wait == c_WAIT_LAST);

  //----------------------------------------------------------------------------
  // Output decode: a function of the state and the latched opcode. The only
  // input terms are the ready qualifiers on exit-edge strobes (so a stalled
  // MEMORY/FETCH never loads a stage register or retires twice) and the branch
  // result selecting the PC source in EXECUTE.
  //----------------------------------------------------------------------------
  always_comb begin
    o_pc_sel    = 1'b0;
    o_if_id_we  = 1'b0;
    o_id_ex_we  = 1'b0;
    o_ex_mem_we = 1'b0;
    o_mem_wb_we = 1'b0;
    o_reg_we    = 1'b0;
    o_reg_re    = 1'b0;
    o_dmem_re   = 1'b0;
    o_dmem_we   = 1'b0;
    o_wb_sel    = 1'b1;
    w_retire    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_if_id_we = i_imem_ready;
      end
      ST_DECODE: begin
        o_id_ex_we = 1'b1;
        // FENCE is a no-op on this datapath and retires here.
        w_retire   = (w_class == CLS_FENCE);
      end
      ST_EXECUTE: begin
        o_ex_mem_we = 1'b1;
        if (w_class == CLS_BRANCH) begin
          w_retire = 1'b1;
          o_pc_sel = i_br_taken;
        end
      end
      ST_MEMORY: begin
        o_mem_wb_we = i_dmem_ready;
        if (w_class == CLS_LOAD) begin
          o_dmem_re = 1'b1;
          o_wb_sel  = 1'b0;
        end else if (w_class == CLS_STORE) begin
          o_dmem_we = 1'b1;
          o_reg_re  = 1'b1;
          // A store retires in MEMORY, but only on the completing cycle.
          w_retire  = i_dmem_ready;
        end
      end
      ST_WRITEBACK: begin
        w_retire = 1'b1;
        o_reg_we = 1'b1;
        o_pc_sel = (w_class == CLS_JUMP);
        o_wb_sel = (w_class != CLS_LOAD);
      end
      default: ;
    endcase
  end

  assign o_pc_we        = w_retire;
  assign o_retire_pulse = w_retire;
  assign o_busy         = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign o_halted       = (r_state == ST_HALT);
  assign o_fault        = r_fault;
  assign o_retire_cnt   = r_retire_cnt;

  //----------------------------------------------------------------------------
  // State, opcode latch, wait counter and retire counter.
  // r_wait defaults to zero every cycle and only advances while a wait state
  // is held, which clears it on every state entry.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_opcode     <= '0;
      r_wait       <= '0;
      r_fault      <= FAULT_NONE;
      r_retire_cnt <= '0;
    end else begin
      r_wait <= '0;
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          // Ready takes priority over a coincident timeout.
          if (i_imem_ready) begin
            r_opcode <= i_imem_op;
            r_state  <= ST_DECODE;
          end else if (w_wait_done) begin
            r_state  <= ST_HALT;
            r_fault  <= FAULT_IMEM_TO;
          end else begin
            r_wait   <= r_wait + c_WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          case (w_class)
            CLS_FENCE:   r_state <= ST_FETCH;
            CLS_SYSTEM:  r_state <= ST_HALT;
            CLS_ILLEGAL: begin
              r_state <= ST_HALT;
              r_fault <= FAULT_ILLEGAL;
            end
            default:     r_state <= ST_EXECUTE;
          endcase
        end
        ST_EXECUTE: begin
          case (w_class)
            CLS_BRANCH:          r_state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: r_state <= ST_MEMORY;
            default:             r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEMORY: begin
          if (i_dmem_ready) begin
            r_state <= (w_class == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
          end else if (w_wait_done) begin
            r_state <= ST_HALT;
            r_fault <= FAULT_DMEM_TO;
          end else begin
            r_wait  <= r_wait + c_WAIT_W'(1);
          end
        end
        ST_WRITEBACK: begin
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          // Terminal until reset; start is deliberately not decoded here.
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_stage_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_rv32i_stage_sequencer
// Description : Self-checking bench for rv32i_stage_sequencer. Instruction
//               vectors carry their expected latency and retire-cycle outputs;
//               each is queued when issued and compared when the DUT retires
//               it. Halt, timeout, mid-instruction reset and counter wrap are
//               exercised by short hand-written sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rv32i_stage_sequencer;

  localparam int MEM_TIMEOUT = 16;
  localparam int RETIRE_W    = 4;   // narrow so the wrap case is reachable

  logic clk = 1'b0;
  logic rst, start, imem_ready, dmem_ready, br_taken;
  logic [6:0] imem_op;
  logic pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic reg_we, reg_re, dmem_re, dmem_we, wb_sel, busy, halted, retire_pulse;
  logic [1:0] fault;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [15:0] outs;

  always #5 clk = ~clk;

  rv32i_stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_imem_ready(imem_ready),
    .i_imem_op(imem_op), .i_dmem_ready(dmem_ready), .i_br_taken(br_taken),
    .o_pc_we(pc_we), .o_pc_sel(pc_sel), .o_if_id_we(if_id_we),
    .o_id_ex_we(id_ex_we), .o_ex_mem_we(ex_mem_we), .o_mem_wb_we(mem_wb_we),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .o_dmem_re(dmem_re),
    .o_dmem_we(dmem_we), .o_wb_sel(wb_sel), .o_busy(busy), .o_halted(halted),
    .o_fault(fault), .o_retire_pulse(retire_pulse), .o_retire_cnt(retire_cnt)
  );

  // Idle/reset image is 16'h0020: only wb_sel (bit 5) high.
  assign outs = {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                 reg_we, reg_re, dmem_re, dmem_we, wb_sel, busy, halted,
                 fault, retire_pulse};

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         dwait;    // dmem wait cycles before ready
    int         cycles;   // busy cycles from FETCH entry to retire, inclusive
    logic       pc_sel;   // at retire
    logic       wb_sel;   // at retire
    int         reg_we;   // reg_we cycles during the instruction
    int         mem_cyc;  // cycles with a dmem request
  } vec_t;

  vec_t exp_q[$];
  vec_t e;
  vec_t tbl[13];
  int n_vec = 0, n_err = 0, n_retired = 0;
  int busy_cnt = 0, mem_cnt = 0, regwe_cnt = 0, pcwe_cnt = 0, total_busy = 0;
  int cur_wait = 0, mem_resp = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic br, input int dw,
                              input int cyc, input logic ps, input logic ws,
                              input int rw, input int mc);
    vec_t v;
    v.op = op; v.br = br; v.dwait = dw; v.cycles = cyc;
    v.pc_sel = ps; v.wb_sel = ws; v.reg_we = rw; v.mem_cyc = mc;
    return v;
  endfunction

  // Retire monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; mem_cnt = 0; regwe_cnt = 0; pcwe_cnt = 0; total_busy = 0;
    end else begin
      if (busy) begin busy_cnt++; total_busy++; end
      if (dmem_re || dmem_we) mem_cnt++;
      if (reg_we) regwe_cnt++;
      if (pc_we) pcwe_cnt++;
      if (retire_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", busy_cnt, e.cycles);
          chk("pc_sel_at_retire", int'(pc_sel), int'(e.pc_sel));
          chk("wb_sel_at_retire", int'(wb_sel), int'(e.wb_sel));
          chk("reg_we_cycles", regwe_cnt, e.reg_we);
          chk("dmem_req_cycles", mem_cnt, e.mem_cyc);
          chk("pc_we_cycles", pcwe_cnt, 1);
        end
        busy_cnt = 0; mem_cnt = 0; regwe_cnt = 0; pcwe_cnt = 0;
        n_retired++;
      end
    end
  end

  // Data-memory responder: ready after cur_wait cycles of a held request.
  task automatic respond();
    if (dmem_re || dmem_we) mem_resp++;
    else mem_resp = 0;
    dmem_ready = (mem_resp > cur_wait);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
    br_taken = 1'b0; imem_op = 7'd0; cur_wait = 0; mem_resp = 0;
    repeat (2) tick();
    chk("reset_outputs", int'(outs), 32'h0020);
    chk("reset_retire_cnt", int'(retire_cnt), 0);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_fetch", int'({busy, if_id_we}), int'({1'b1, imem_ready}));
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int guard;
    imem_op = v.op; br_taken = v.br; cur_wait = v.dwait;
    exp_q.push_back(v);
    base = n_retired;
    guard = 0;
    while (n_retired == base && guard < 64) begin
      tick();
      guard++;
    end
    chk("retire_seen", n_retired - base, 1);
  endtask

  // Run to HALT and check the fault-onset cycle.
  task automatic run_halt(input string name, input logic [6:0] op, input int dw,
                          input int exp_busy, input int exp_fault, input int exp_mem);
    int guard;
    imem_op = op; cur_wait = dw;
    guard = 0;
    while (!halted && guard < 64) begin
      tick();
      guard++;
    end
    chk({name, "_halted"}, int'(halted), 1);
    chk({name, "_fault"}, int'(fault), exp_fault);
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({name, "_mem_cycles"}, mem_cnt, exp_mem);
    chk({name, "_no_pcwe_regwe_busy"}, int'({pc_we, reg_we, busy, dmem_we}), 0);
  endtask

  initial begin
    tbl[0]  = mk(7'b0010011, 1'b0, 0, 4, 1'b0, 1'b1, 1, 0); // ADDI
    tbl[1]  = mk(7'b0000011, 1'b0, 0, 5, 1'b0, 1'b0, 1, 1); // LW
    tbl[2]  = mk(7'b0100011, 1'b0, 0, 4, 1'b0, 1'b1, 0, 1); // SW
    tbl[3]  = mk(7'b1100011, 1'b1, 0, 3, 1'b1, 1'b1, 0, 0); // BEQ taken
    tbl[4]  = mk(7'b1101111, 1'b0, 0, 4, 1'b1, 1'b1, 1, 0); // JAL
    tbl[5]  = mk(7'b0000011, 1'b0, 3, 8, 1'b0, 1'b0, 1, 4); // LW, 3 waits
    tbl[6]  = mk(7'b0100011, 1'b0, 2, 6, 1'b0, 1'b1, 0, 3); // SW, 2 waits
    tbl[7]  = mk(7'b1100011, 1'b0, 0, 3, 1'b0, 1'b1, 0, 0); // branch not taken
    tbl[8]  = mk(7'b1100111, 1'b0, 0, 4, 1'b1, 1'b1, 1, 0); // JALR
    tbl[9]  = mk(7'b0110111, 1'b0, 0, 4, 1'b0, 1'b1, 1, 0); // LUI
    tbl[10] = mk(7'b0010111, 1'b0, 0, 4, 1'b0, 1'b1, 1, 0); // AUIPC
    tbl[11] = mk(7'b0110011, 1'b0, 0, 4, 1'b0, 1'b1, 1, 0); // OP
    tbl[12] = mk(7'b0001111, 1'b0, 0, 2, 1'b0, 1'b1, 0, 0); // FENCE

    // Main stream, then the remaining table entries back to back.
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    chk("stream_total_cycles", total_busy, 20);
    chk("stream_retire_cnt", int'(retire_cnt), 5);
    for (int i = 5; i < 13; i++) run_vec(tbl[i]);
    chk("table_retire_cnt", int'(retire_cnt), 13);

    // Store that never completes: dmem timeout.
    do_reset();
    do_start();
    run_vec(tbl[0]);
    run_halt("sw_timeout", 7'b0100011, 1000, 19, 3, 16);
    chk("sw_timeout_retire_cnt", int'(retire_cnt), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("halt_ignores_start", int'({halted, busy}), 2);

    // Illegal opcode.
    do_reset();
    do_start();
    run_halt("illegal", 7'h7F, 0, 2, 1, 0);

    // SYSTEM halts cleanly.
    do_reset();
    do_start();
    run_halt("system", 7'b1110011, 0, 2, 0, 0);

    // Instruction memory never ready.
    do_reset();
    imem_ready = 1'b0;
    do_start();
    run_halt("fetch_timeout", 7'b0010011, 0, 16, 2, 0);

    // Reset in the MEMORY state of a stalled store.
    do_reset();
    do_start();
    run_vec(tbl[0]);
    imem_op = 7'b0100011; cur_wait = 1000;
    for (int g = 0; g < 16 && !dmem_we; g++) tick();
    chk("sw_reached_memory", int'(dmem_we), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_outputs", int'(outs), 32'h0020);
    chk("mid_reset_retire_cnt", int'(retire_cnt), 0);
    tick();
    chk("mid_reset_stays_idle", int'(outs), 32'h0020);

    // Counter wrap: fill to all-ones, then one more.
    do_reset();
    do_start();
    for (int i = 0; i < 15; i++) run_vec(tbl[0]);
    chk("retire_cnt_all_ones", int'(retire_cnt), 15);
    run_vec(tbl[0]);
    chk("retire_cnt_wrap", int'(retire_cnt), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
